sprite_compositor: RTL

Pixel-side consumer of the game-logic sprite positions. It samples the pacman and four ghost positions once per frame and tests every scanned pixel against the five 16×16 sprite boxes. It looks up sprite bitmaps and outputs a composited 12-bit RGB pixel, with priority over a background colour, to the VGA output stage. It sits between the game-logic top level and the display timing/colour output path.

---
 rtl/sprite_pkg.sv | 77 +++++++
 rtl/sprite_rom.sv | 17 +
 rtl/sprite_compositor.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite compositor: direction codes, sprite IDs,
// default colours and the two 16x16 sprite bitmaps.
package sprite_pkg;

    localparam int SPRITE_W    = 16;
    localparam int NUM_SPRITES = 5;

    // One-hot pacman movement directions.
    typedef enum logic [3:0] {
        RIGHT = 4'b0001,
        UP    = 4'b0010,
        DOWN  = 4'b0100,
        LEFT  = 4'b1000
    } dir_e;

    // Sprite IDs, also the priority order (lower ID wins).
    typedef enum logic [2:0] {
        PACMAN = 3'd0,
        BLINKY = 3'd1,
        PINKY  = 3'd2,
        INKY   = 3'd3,
        CLYDE  = 3'd4
    } sprite_id_e;

    localparam logic [11:0] DEFAULT_PACMAN_RGB = 12'hFF0;
    localparam logic [11:0] DEFAULT_BLINKY_RGB = 12'hF00;
    localparam logic [11:0] DEFAULT_PINKY_RGB  = 12'hF8C;
    localparam logic [11:0] DEFAULT_INKY_RGB   = 12'h0FF;
    localparam logic [11:0] DEFAULT_CLYDE_RGB  = 12'hF80;

    // True when exactly one bit of the direction code is set.
    function automatic logic is_onehot4(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

    // Pacman facing right; bit 15 is the leftmost column.
    function automatic logic [15:0] pacman_row(input logic [3:0] row);
        logic [15:0] bits;
        case (row)
            4'd0:  bits = 16'hFFF0;
            4'd1:  bits = 16'hFFF8;
            4'd2:  bits = 16'hFFFC;
            4'd3:  bits = 16'hFFFE;
            4'd4:  bits = 16'hFFF8;
            4'd5:  bits = 16'hFFE0;
            4'd6:  bits = 16'hFF80;
            4'd7:  bits = 16'hFE00;
            4'd8:  bits = 16'hFE00;
            4'd9:  bits = 16'hFF80;
            4'd10: bits = 16'hFFE0;
            4'd11: bits = 16'hFFF8;
            4'd12: bits = 16'hFFFE;
            4'd13: bits = 16'hFFFC;
            4'd14: bits = 16'hFFF8;
            default: bits = 16'h7FF0;
        endcase
        return bits;
    endfunction

    // Ghost body with eye holes and a ragged hem.
    function automatic logic [15:0] ghost_row(input logic [3:0] row);
        logic [15:0] bits;
        case (row)
            4'd0:  bits = 16'h07E0;
            4'd1:  bits = 16'h1FF8;
            4'd2:  bits = 16'h3FFC;
            4'd3:  bits = 16'h7FFE;
            4'd4:  bits = 16'h7FFE;
            4'd5:  bits = 16'hC3C3;
            4'd6:  bits = 16'hC3C3;
            4'd15: bits = 16'hE667;
            default: bits = 16'hFFFF;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous single-port sprite bitmap ROM, one 16-bit row per address,
// one cycle read latency. SHAPE selects the bitmap: 0 = pacman, 1 = ghost.
module sprite_rom #(
    parameter int SHAPE = 0
) (
    input  logic        clk,
    input  logic [3:0]  addr,
    output logic [15:0] data
);
    import sprite_pkg::*;

    // Registered row read.
    always_ff @(posedge clk) begin
        data <= (SHAPE == 0) ? pacman_row(addr) : ghost_row(addr);
    end

endmodule

// File: rtl/sprite_compositor.sv
// Sprite compositor: latches sprite positions once per frame, hit-tests each
// scanned pixel against five 16x16 boxes, looks up bitmaps and outputs the
// highest-priority opaque colour (or the background) two cycles later.
// Optional feature macro: SPRITE_DEATH_BLINK_EN (blink pacman while dead).
module sprite_compositor #(
    parameter int          SPRITE_W   = 16,
    parameter logic [11:0] PACMAN_RGB = 12'hFF0,
    parameter logic [11:0] BLINKY_RGB = 12'hF00,
    parameter logic [11:0] PINKY_RGB  = 12'hF8C,
    parameter logic [11:0] INKY_RGB   = 12'h0FF,
    parameter logic [11:0] CLYDE_RGB  = 12'hF80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [10:0] pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_active,
    input  logic [11:0] bg_rgb,
    input  logic [10:0] pacman_pos_x,
    input  logic [10:0] blinky_pos_x,
    input  logic [10:0] pinky_pos_x,
    input  logic [10:0] inky_pos_x,
    input  logic [10:0] clyde_pos_x,
    input  logic [9:0]  pacman_pos_y,
    input  logic [9:0]  blinky_pos_y,
    input  logic [9:0]  pinky_pos_y,
    input  logic [9:0]  inky_pos_y,
    input  logic [9:0]  clyde_pos_y,
    input  logic        pacman_is_dead,
    input  logic [3:0]  pacman_moving_dir,
    output logic [11:0] rgb_out,
    output logic        rgb_valid
);
    import sprite_pkg::*;

    localparam int N = NUM_SPRITES;

    // Flatten the per-sprite ports into arrays indexed by sprite ID.
    logic [10:0] pos_x      [N];
    logic [9:0]  pos_y      [N];
    logic [11:0] sprite_rgb [N];

    assign pos_x[PACMAN] = pacman_pos_x;
    assign pos_x[BLINKY] = blinky_pos_x;
    assign pos_x[PINKY]  = pinky_pos_x;
    assign pos_x[INKY]   = inky_pos_x;
    assign pos_x[CLYDE]  = clyde_pos_x;
    assign pos_y[PACMAN] = pacman_pos_y;
    assign pos_y[BLINKY] = blinky_pos_y;
    assign pos_y[PINKY]  = pinky_pos_y;
    assign pos_y[INKY]   = inky_pos_y;
    assign pos_y[CLYDE]  = clyde_pos_y;
    assign sprite_rgb[PACMAN] = PACMAN_RGB;
    assign sprite_rgb[BLINKY] = BLINKY_RGB;
    assign sprite_rgb[PINKY]  = PINKY_RGB;
    assign sprite_rgb[INKY]   = INKY_RGB;
    assign sprite_rgb[CLYDE]  = CLYDE_RGB;

    // Per-frame shadow copies; rendering only ever looks at these.
    logic [10:0] sh_x [N];
    logic [9:0]  sh_y [N];
    logic [3:0]  sh_dir;
    logic        sh_dead;

    // Capture all sprite state on frame_start; ignore malformed directions.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N; s++) begin
                sh_x[s] <= '0;
                sh_y[s] <= '0;
            end
            sh_dir  <= RIGHT;
            sh_dead <= 1'b0;
        end else if (frame_start) begin
            for (int s = 0; s < N; s++) begin
                sh_x[s] <= pos_x[s];
                sh_y[s] <= pos_y[s];
            end
            sh_dead <= pacman_is_dead;
            if (is_onehot4(pacman_moving_dir)) begin
                sh_dir <= pacman_moving_dir;
            end
        end
    end

    logic pacman_hidden;

`ifdef SPRITE_DEATH_BLINK_EN
    logic [4:0] blink_cnt;

    // Count dead frames (saturating); any live frame restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
        end else if (frame_start) begin
            if (!pacman_is_dead) begin
                blink_cnt <= '0;
            end else if (blink_cnt != 5'd31) begin
                blink_cnt <= blink_cnt + 5'd1;
            end
        end
    end

    assign pacman_hidden = sh_dead & blink_cnt[3];
`else
    logic unused_dead;
    assign unused_dead   = sh_dead;
    assign pacman_hidden = 1'b0;
`endif

    // Stage 0: hit test and bitmap addressing from the shadow positions.
    logic [11:0] dx       [N];
    logic [10:0] dy       [N];
    logic [3:0]  row_addr [N];
    logic [3:0]  col_idx  [N];
    logic [4:0]  hit;

    // Box test per sprite; the subtraction MSB is the borrow, so nothing wraps.
    always_comb begin
        hit = '0;
        for (int s = 0; s < N; s++) begin
            dx[s]       = {1'b0, pixel_x} - {1'b0, sh_x[s]};
            dy[s]       = {1'b0, pixel_y} - {1'b0, sh_y[s]};
            hit[s]      = !dx[s][11] && !dy[s][10] &&
                          (dx[s][10:0] < 11'(SPRITE_W)) &&
                          (dy[s][9:0] < 10'(SPRITE_W));
            row_addr[s] = dy[s][3:0];
            col_idx[s]  = dx[s][3:0];
        end
        if (pacman_hidden) begin
            hit[PACMAN] = 1'b0;
        end
        // Rotate/mirror the pacman lookup; ~v on 4 bits is 15 - v.
        case (sh_dir)
            LEFT: col_idx[PACMAN] = ~dx[PACMAN][3:0];
            UP: begin
                row_addr[PACMAN] = ~dx[PACMAN][3:0];
                col_idx[PACMAN]  = dy[PACMAN][3:0];
            end
            DOWN: begin
                row_addr[PACMAN] = dx[PACMAN][3:0];
                col_idx[PACMAN]  = dy[PACMAN][3:0];
            end
            default: ;
        endcase
    end

    // Stage 1 registers, aligned with the ROM read data.
    logic [4:0]  s1_hit;
    logic [3:0]  s1_col [N];
    logic [11:0] s1_bg;
    logic        s1_active;

    // Pipeline stage 1; reset flushes hits and the active flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit    <= '0;
            s1_bg     <= '0;
            s1_active <= 1'b0;
            for (int s = 0; s < N; s++) begin
                s1_col[s] <= '0;
            end
        end else begin
            s1_hit    <= hit;
            s1_bg     <= bg_rgb;
            s1_active <= video_active;
            for (int s = 0; s < N; s++) begin
                s1_col[s] <= col_idx[s];
            end
        end
    end

    logic [15:0] rom_data [N];

    for (genvar s = 0; s < N; s++) begin : g_rom
        sprite_rom #(
            .SHAPE((s == 0) ? 0 : 1)
        ) u_rom (
            .clk  (clk),
            .addr (row_addr[s]),
            .data (rom_data[s])
        );
    end

    // Stage 2: bit select and priority; the loop runs low-priority first so
    // the lowest sprite ID overwrites last.
    logic [4:0]  opaque;
    logic [11:0] pix;

    // Pick the winning colour among opaque sprite pixels.
    always_comb begin
        opaque = '0;
        pix    = s1_bg;
        for (int s = 0; s < N; s++) begin
            opaque[s] = s1_hit[s] & rom_data[s][~s1_col[s]];
        end
        for (int s = N - 1; s >= 0; s--) begin
            if (opaque[s]) begin
                pix = sprite_rgb[s];
            end
        end
    end

    // Output register with blanking outside the visible area.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out   <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rgb_valid <= s1_active;
            rgb_out   <= s1_active ? pix : 12'h000;
        end
    end

endmodule
